stereo_axis_frame_gen: RTL and testbench

//  Synthetic stereo-pair video source feeding the Stereovision core's image input.

---
 rtl/stereo_axis_frame_gen.sv | 147 ++++++++++++++
 tb/tb_stereo_axis_frame_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_axis_frame_gen.sv
// Synthetic stereo-pair AXI4-Stream frame source: left = x+y, right = x+y+shift,
// reserved lane zero; SOF on tuser, EOL on tlast, optional idle gap after each line.
module stereo_axis_frame_gen #(
  parameter int WIDTH             = 3840,
  parameter int HEIGHT            = 2160,
  parameter int SAMPLES_PER_CLOCK = 4,
  parameter int DATA_WIDTH        = 8,
  parameter int AXIS_TDATA_WIDTH  = 96,
  parameter int H_BLANK           = 0
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        start,
  input  logic [7:0]                  disp_shift,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        m_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready
);

  localparam int BEATS   = WIDTH / SAMPLES_PER_CLOCK;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int Y_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BLANK_W = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
  localparam int LANE_W  = SAMPLES_PER_CLOCK * DATA_WIDTH;

  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [Y_W-1:0]     LAST_Y     = Y_W'(HEIGHT - 1);
  localparam logic [BLANK_W-1:0] LAST_BLANK = BLANK_W'(H_BLANK - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HBLANK} state_e;

  state_e                      state_q, state_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic [Y_W-1:0]              y_q, y_d;
  logic [7:0]                  shift_q, shift_d;
  logic [BLANK_W-1:0]          blank_q, blank_d;
  logic                        busy_q, busy_d;
  logic                        frame_done_q, frame_done_d;
  logic                        tvalid_q, tvalid_d;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                        tuser_q, tuser_d;
  logic                        tlast_q, tlast_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    beat_d       = beat_q;
    y_d          = y_q;
    shift_d      = shift_q;
    blank_d      = blank_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACTIVE;
          shift_d = disp_shift;
          beat_d  = '0;
          y_d     = '0;
        end
      end
      ST_ACTIVE: begin
        if (tvalid_q && m_axis_tready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (y_q == LAST_Y) begin
              frame_done_d = 1'b1;
              y_d          = '0;
              if (start) shift_d = disp_shift;
              else       state_d = ST_IDLE;
            end else begin
              y_d = y_q + 1'b1;
              if (H_BLANK > 0) begin
                state_d = ST_HBLANK;
                blank_d = '0;
              end
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_HBLANK: begin
        if (blank_q == LAST_BLANK) state_d = ST_ACTIVE;
        else                       blank_d = blank_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs describe the beat the counters will point at next cycle, so they stay
    // frozen while the sink stalls and update in the same edge as the handshake.
    busy_d   = (state_d != ST_IDLE);
    tvalid_d = (state_d == ST_ACTIVE);
    tuser_d  = tvalid_d && (beat_d == '0) && (y_d == '0);
    tlast_d  = tvalid_d && (beat_d == LAST_BEAT);
    tdata_d  = '0;
    if (tvalid_d) begin
      for (int k = 0; k < SAMPLES_PER_CLOCK; k++) begin
        tdata_d[k*DATA_WIDTH +: DATA_WIDTH] =
          DATA_WIDTH'(32'(beat_d) * SAMPLES_PER_CLOCK + k + 32'(y_d));
        tdata_d[LANE_W + k*DATA_WIDTH +: DATA_WIDTH] =
          DATA_WIDTH'(32'(beat_d) * SAMPLES_PER_CLOCK + k + 32'(y_d) + 32'(shift_d));
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      y_q          <= '0;
      shift_q      <= '0;
      blank_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tuser_q      <= 1'b0;
      tlast_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      y_q          <= y_d;
      shift_q      <= shift_d;
      blank_q      <= blank_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      tuser_q      <= tuser_d;
      tlast_q      <= tlast_d;
    end
  end

  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_stereo_axis_frame_gen.sv
// Self-checking bench for stereo_axis_frame_gen: random backpressure, beats compared
// against an arithmetic model of the pixel pattern and frame timing.
module tb_stereo_axis_frame_gen;

  localparam int W     = 16;
  localparam int H     = 4;
  localparam int SPC   = 4;
  localparam int HB    = 2;
  localparam int BPL   = W / SPC;
  localparam int BPF   = BPL * H;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start;
  logic [7:0]  disp_shift;
  logic        busy, frame_done, m_axis_tvalid, m_axis_tuser, m_axis_tlast;
  logic [95:0] m_axis_tdata;
  logic        m_axis_tready;

  stereo_axis_frame_gen #(
    .WIDTH(W), .HEIGHT(H), .SAMPLES_PER_CLOCK(SPC), .DATA_WIDTH(8),
    .AXIS_TDATA_WIDTH(96), .H_BLANK(HB)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .disp_shift(disp_shift),
    .busy(busy), .frame_done(frame_done), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [95:0] d;
    logic        u;
    logic        l;
    int          cyc;
  } beat_t;

  beat_t beats[$];
  int    fd_q[$];
  int    cyc;
  int    stall_err;
  bit    timed_out;
  int    n_checks;
  int    n_pass;

  // Expected {tuser, tlast, tdata} for beat b of row y with shift s.
  function automatic logic [97:0] exp_beat(input int y, input int b, input int s);
    logic [95:0] d;
    d = '0;
    for (int k = 0; k < SPC; k++) begin
      d[8*k +: 8]      = 8'((b*SPC + k + y) % 256);
      d[32 + 8*k +: 8] = 8'((b*SPC + k + y + s) % 256);
    end
    return {(b == 0 && y == 0), (b == BPL-1), d};
  endfunction

  function automatic logic [97:0] exp_idx(input int i, input int s);
    return exp_beat((i % BPF) / BPL, i % BPL, s);
  endfunction

  // Collects n accepted beats under random tready; drops start / changes disp_shift
  // after the given accepted-beat counts (0 = never), then runs extra idle cycles.
  task automatic capture(input int n, input int ready_pct, input int drop_at,
                         input int chg_at, input logic [7:0] chg_val, input int extra);
    int got = 0, ext = 0, budget = n * 10 + 100;
    bit stalled = 1'b0;
    logic [95:0] hd;
    logic hu, hl;
    beat_t bt;
    beats.delete();
    fd_q.delete();
    stall_err = 0;
    timed_out = 1'b0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (stalled && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hd ||
                      m_axis_tuser !== hu || m_axis_tlast !== hl))
        stall_err++;
      if (frame_done === 1'b1) fd_q.push_back(cyc);
      m_axis_tready = (got < n) ? ($urandom_range(99) < ready_pct) : 1'b1;
      if (got < n && m_axis_tvalid && m_axis_tready) begin
        bt.d = m_axis_tdata; bt.u = m_axis_tuser; bt.l = m_axis_tlast; bt.cyc = cyc;
        beats.push_back(bt);
        got++;
        if (got == drop_at) start = 1'b0;
        if (got == chg_at)  disp_shift = chg_val;
      end else if (got >= n) begin
        if (ext >= extra) break;
        ext++;
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      hd = m_axis_tdata; hu = m_axis_tuser; hl = m_axis_tlast;
      budget--;
      if (budget == 0) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    aresetn = 1'b0; start = 1'b0; disp_shift = 8'd0; m_axis_tready = 1'b0;
    #12;
    n_checks++;
    if ({busy, frame_done, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata} !== '0)
      $display("FAIL reset_outputs: got busy=%b fd=%b v=%b u=%b l=%b d=%h, want all 0",
               busy, frame_done, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata);
    else n_pass++;
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      n_checks++;
      if (m_axis_tvalid !== 1'b0 || busy !== 1'b0)
        $display("FAIL idle_after_reset[%0d]: tvalid=%b busy=%b, want 0/0", i, m_axis_tvalid, busy);
      else n_pass++;
    end
  endtask

  task automatic test_basic;
    @(negedge aclk);
    disp_shift = 8'd3; start = 1'b1;
    capture(BPF, 100, 1, 0, 8'd0, 4);
    n_checks++;
    if (timed_out || beats.size() != BPF) $display("FAIL basic_timeout: got %0d beats, want %0d", beats.size(), BPF);
    else n_pass++;
    for (int i = 0; i < beats.size(); i++) begin
      n_checks++;
      if ({beats[i].u, beats[i].l, beats[i].d} !== exp_idx(i, 3))
        $display("FAIL basic_beat[%0d]: got %h, want %h", i, {beats[i].u, beats[i].l, beats[i].d}, exp_idx(i, 3));
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (beats[i].cyc - beats[i-1].cyc != ((i % BPL == 0) ? HB + 1 : 1))
          $display("FAIL basic_gap[%0d]: got %0d cycles, want %0d", i,
                   beats[i].cyc - beats[i-1].cyc, (i % BPL == 0) ? HB + 1 : 1);
        else n_pass++;
      end
    end
    if (beats.size() == BPF) begin
      n_checks++;
      if (beats[0].d[31:0] !== 32'h03020100 || beats[0].d[63:32] !== 32'h06050403 ||
          beats[BPL].d[31:0] !== 32'h04030201)
        $display("FAIL basic_known_pixels: got %h %h %h, want 03020100 06050403 04030201",
                 beats[0].d[31:0], beats[0].d[63:32], beats[BPL].d[31:0]);
      else n_pass++;
      n_checks++;
      if (fd_q.size() != 1 || fd_q[0] != beats[BPF-1].cyc + 1)
        $display("FAIL basic_frame_done: got %0d pulses, want 1 at cycle %0d", fd_q.size(), beats[BPF-1].cyc + 1);
      else n_pass++;
    end
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || beats[0].d[95:64] !== 32'h0)
      $display("FAIL basic_end_idle: tvalid=%b busy=%b rsvd=%h, want 0/0/0", m_axis_tvalid, busy, beats[0].d[95:64]);
    else n_pass++;
  endtask

  task automatic test_random_ready;
    @(negedge aclk);
    disp_shift = 8'd3; start = 1'b1;
    capture(BPF, 50, 1, 0, 8'd0, 4);
    n_checks++;
    if (timed_out || beats.size() != BPF || stall_err != 0)
      $display("FAIL stall_hold: got %0d beats %0d stall violations, want %0d/0", beats.size(), stall_err, BPF);
    else n_pass++;
    for (int i = 0; i < beats.size(); i++) begin
      n_checks++;
      if ({beats[i].u, beats[i].l, beats[i].d} !== exp_idx(i, 3))
        $display("FAIL stall_beat[%0d]: got %h, want %h", i, {beats[i].u, beats[i].l, beats[i].d}, exp_idx(i, 3));
      else n_pass++;
    end
  endtask

  task automatic test_wrap_and_shift_latch;
    logic [7:0] s2;
    s2 = 8'($urandom_range(0, 254));
    @(negedge aclk);
    disp_shift = 8'd255; start = 1'b1;
    capture(2*BPF, 70, BPF + BPL + 1, 5, s2, 4);
    n_checks++;
    if (timed_out || beats.size() != 2*BPF || stall_err != 0)
      $display("FAIL wrap_run: got %0d beats %0d stall violations, want %0d/0", beats.size(), stall_err, 2*BPF);
    else n_pass++;
    if (beats.size() > 0) begin
      n_checks++;
      if (beats[0].d[47:40] !== 8'h00)
        $display("FAIL wrap_pixel: got right x=1 y=0 = %h, want 00", beats[0].d[47:40]);
      else n_pass++;
    end
    for (int i = 0; i < beats.size(); i++) begin
      n_checks++;
      if ({beats[i].u, beats[i].l, beats[i].d} !== exp_idx(i, (i < BPF) ? 255 : int'(s2)))
        $display("FAIL shift_latch_beat[%0d]: got %h, want %h", i,
                 {beats[i].u, beats[i].l, beats[i].d}, exp_idx(i, (i < BPF) ? 255 : int'(s2)));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] s;
    s = 8'($urandom);
    @(negedge aclk);
    disp_shift = s; start = 1'b1;
    capture(2*BPF, 100, BPF + BPL + 1, 0, 8'd0, 4);
    n_checks++;
    if (timed_out || beats.size() != 2*BPF)
      $display("FAIL b2b_run: got %0d beats, want %0d", beats.size(), 2*BPF);
    else n_pass++;
    for (int i = 0; i < beats.size(); i++) begin
      n_checks++;
      if ({beats[i].u, beats[i].l, beats[i].d} !== exp_idx(i, int'(s)))
        $display("FAIL b2b_beat[%0d]: got %h, want %h", i, {beats[i].u, beats[i].l, beats[i].d}, exp_idx(i, int'(s)));
      else n_pass++;
    end
    if (beats.size() == 2*BPF) begin
      n_checks++;
      if (beats[BPF].cyc != beats[BPF-1].cyc + 1 || beats[BPF].u !== 1'b1)
        $display("FAIL b2b_no_gap: got gap %0d tuser=%b, want 1/1", beats[BPF].cyc - beats[BPF-1].cyc, beats[BPF].u);
      else n_pass++;
      n_checks++;
      if (fd_q.size() != 2 || fd_q[0] != beats[BPF-1].cyc + 1 || fd_q[1] != beats[2*BPF-1].cyc + 1)
        $display("FAIL b2b_frame_done: got %0d pulses, want 2", fd_q.size());
      else n_pass++;
    end
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0)
      $display("FAIL b2b_stop: tvalid=%b busy=%b, want 0/0", m_axis_tvalid, busy);
    else n_pass++;
  endtask

  task automatic test_reset_abort;
    logic [7:0] s;
    s = 8'($urandom);
    @(negedge aclk);
    disp_shift = 8'd9; start = 1'b1;
    capture(2*BPL + 1, 100, 0, 0, 8'd0, 0);
    #1 aresetn = 1'b0;
    #1;
    n_checks++;
    if ({busy, frame_done, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata} !== '0)
      $display("FAIL abort_outputs: got busy=%b v=%b d=%h, want all 0", busy, m_axis_tvalid, m_axis_tdata);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      n_checks++;
      if (frame_done !== 1'b0 || m_axis_tvalid !== 1'b0)
        $display("FAIL abort_hold[%0d]: frame_done=%b tvalid=%b, want 0/0", i, frame_done, m_axis_tvalid);
      else n_pass++;
    end
    disp_shift = s; aresetn = 1'b1;
    capture(BPF, 100, 1, 0, 8'd0, 4);
    n_checks++;
    if (timed_out || beats.size() != BPF || beats[0].u !== 1'b1 || beats[0].d[31:0] !== 32'h03020100)
      $display("FAIL abort_restart: got %0d beats, first tuser/left, want %0d beats tuser=1 left=03020100", beats.size(), BPF);
    else n_pass++;
    for (int i = 0; i < beats.size(); i++) begin
      n_checks++;
      if ({beats[i].u, beats[i].l, beats[i].d} !== exp_idx(i, int'(s)))
        $display("FAIL abort_beat[%0d]: got %h, want %h", i, {beats[i].u, beats[i].l, beats[i].d}, exp_idx(i, int'(s)));
      else n_pass++;
    end
    n_checks++;
    if (fd_q.size() != 1)
      $display("FAIL abort_frame_done: got %0d pulses, want 1", fd_q.size());
    else n_pass++;
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_pass = 0;
    test_reset();
    test_basic();
    test_random_ready();
    test_wrap_and_shift_latch();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
